// File: rtl/pipeline_sequencer.sv
// rtl/pipeline_sequencer.sv - stall/flush/freeze sequencer for the 3-stage pipeline
//
// Purpose:
//   Arbitrates load-use stalls, taken branches, multi-cycle MUL/DIV launches
//   and halt/resume. It drives the per-stage register enables, the s1 flush,
//   the s2 bubble and the MUL/DIV launch pulse. Outputs are Mealy, so an event
//   takes effect in the cycle it is seen.
//
// Parameters:
//   MD_TIMEOUT  - MD_WAIT cycles allowed before md_err / HALT (2..2^CNT_W-1)
//   FLUSH_DEPTH - cycles s1_flush stays high after a taken branch (1..4)
//   CNT_W       - width of the stall-cycle counter and the MD timeout counter
//
// Optional feature macro:
//   PIPE_PERF_CNT_EN - when defined, stall_cycles counts cycles with pc_en==0
//                      (saturating). When undefined, stall_cycles is tied to 0.
//
// Ports:
//   clk, rst_n      - clock (rising edge), asynchronous active-low reset
//   load_use_stall  - hazard unit stall request
//   branch_taken    - s2 branch resolved taken
//   md_start        - MUL/DIV instruction in s2 needs launch
//   md_done         - MUL/DIV result valid pulse
//   halt_req        - HALT opcode reached s2
//   resume          - external resume request (level)
//   pc_en, s1_en, s2_en, s3_en - pipeline register enables
//   s1_flush        - s1 register loads NOP
//   s2_bubble       - NOP injected into the s2->s3 register
//   md_go           - one-cycle launch pulse to MUL/DIV
//   halted          - sequencer is in HALT
//   md_err          - MUL/DIV timeout seen, sticky until resume
//   stall_cycles    - saturating count of cycles with pc_en==0

module pipeline_sequencer #(
    parameter int MD_TIMEOUT  = 64,
    parameter int FLUSH_DEPTH = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_use_stall,
    input  logic             branch_taken,
    input  logic             md_start,
    input  logic             md_done,
    input  logic             halt_req,
    input  logic             resume,
    output logic             pc_en,
    output logic             s1_en,
    output logic             s2_en,
    output logic             s3_en,
    output logic             s1_flush,
    output logic             s2_bubble,
    output logic             md_go,
    output logic             halted,
    output logic             md_err,
    output logic [CNT_W-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_FLUSH   = 2'd2,
        ST_HALT    = 2'd3
    } state_t;

    // Last MD_WAIT cycle index: the counter starts at 0 on entry, so the
    // MD_TIMEOUT-th waiting cycle sees MD_TIMEOUT-1.
    localparam logic [CNT_W-1:0] MD_LAST    = CNT_W'(MD_TIMEOUT - 1);
    localparam logic [2:0]       FLUSH_INIT = 3'(FLUSH_DEPTH - 1);

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] md_cnt;
    logic [CNT_W-1:0] md_cnt_nxt;
    logic [2:0]       flush_cnt;
    logic [2:0]       flush_cnt_nxt;
    logic             md_err_q;
    logic             md_err_nxt;

    // Ungated Mealy outputs; the port values are forced low while rst_n is low.
    logic pc_en_c;
    logic s1_en_c;
    logic s2_en_c;
    logic s3_en_c;
    logic s1_flush_c;
    logic s2_bubble_c;
    logic md_go_c;
    logic halted_c;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_RUN;
            md_cnt    <= '0;
            flush_cnt <= '0;
            md_err_q  <= 1'b0;
        end else begin
            state     <= state_nxt;
            md_cnt    <= md_cnt_nxt;
            flush_cnt <= flush_cnt_nxt;
            md_err_q  <= md_err_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt     = state;
        md_cnt_nxt    = md_cnt;
        flush_cnt_nxt = flush_cnt;
        md_err_nxt    = md_err_q;
        case (state)
            ST_RUN: begin
                // Priority halt > load-use > md_start > branch; losers are
                // held upstream and re-presented later.
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else if (load_use_stall) begin
                    state_nxt = ST_RUN;
                end else if (md_start) begin
                    state_nxt  = ST_MD_WAIT;
                    md_cnt_nxt = '0;
                end else if (branch_taken && (FLUSH_DEPTH > 1)) begin
                    state_nxt     = ST_FLUSH;
                    flush_cnt_nxt = FLUSH_INIT;
                end
            end
            ST_MD_WAIT: begin
                md_cnt_nxt = md_cnt + CNT_W'(1);
                // md_done wins over a timeout landing in the same cycle.
                if (md_done) begin
                    state_nxt = ST_RUN;
                end else if (md_cnt == MD_LAST) begin
                    state_nxt  = ST_HALT;
                    md_err_nxt = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (halt_req) begin
                    state_nxt = ST_HALT;
                end else begin
                    flush_cnt_nxt = flush_cnt - 3'd1;
                    if (flush_cnt == 3'd1) begin
                        state_nxt = ST_RUN;
                    end
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_nxt  = ST_RUN;
                    md_err_nxt = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_RUN;
            end
        endcase
    end

    // Output logic
    always_comb begin
        pc_en_c     = 1'b1;
        s1_en_c     = 1'b1;
        s2_en_c     = 1'b1;
        s3_en_c     = 1'b1;
        s1_flush_c  = 1'b0;
        s2_bubble_c = 1'b0;
        md_go_c     = 1'b0;
        halted_c    = 1'b0;
        case (state)
            ST_RUN: begin
                if (halt_req) begin
                    pc_en_c = 1'b0;
                    s1_en_c = 1'b0;
                    s2_en_c = 1'b0;
                    s3_en_c = 1'b0;
                end else if (load_use_stall) begin
                    // Hold PC and s1, let the older instructions drain.
                    pc_en_c     = 1'b0;
                    s1_en_c     = 1'b0;
                    s2_bubble_c = 1'b1;
                end else if (md_start) begin
                    md_go_c     = 1'b1;
                    pc_en_c     = 1'b0;
                    s1_en_c     = 1'b0;
                    s2_en_c     = 1'b0;
                    s2_bubble_c = 1'b1;
                end else if (branch_taken) begin
                    s1_flush_c = 1'b1;
                end
            end
            ST_MD_WAIT: begin
                // On md_done s2 captures the result with all enables high.
                if (!md_done) begin
                    pc_en_c     = 1'b0;
                    s1_en_c     = 1'b0;
                    s2_en_c     = 1'b0;
                    s2_bubble_c = 1'b1;
                end
            end
            ST_FLUSH: begin
                if (halt_req) begin
                    pc_en_c = 1'b0;
                    s1_en_c = 1'b0;
                    s2_en_c = 1'b0;
                    s3_en_c = 1'b0;
                end else begin
                    s1_flush_c = 1'b1;
                end
            end
            ST_HALT: begin
                pc_en_c  = 1'b0;
                s1_en_c  = 1'b0;
                s2_en_c  = 1'b0;
                s3_en_c  = 1'b0;
                halted_c = 1'b1;
            end
            default: begin
                pc_en_c = 1'b0;
            end
        endcase
    end

    // Everything drops the moment reset asserts, independent of the clock.
    assign pc_en     = rst_n & pc_en_c;
    assign s1_en     = rst_n & s1_en_c;
    assign s2_en     = rst_n & s2_en_c;
    assign s3_en     = rst_n & s3_en_c;
    assign s1_flush  = rst_n & s1_flush_c;
    assign s2_bubble = rst_n & s2_bubble_c;
    assign md_go     = rst_n & md_go_c;
    assign halted    = rst_n & halted_c;
    assign md_err    = md_err_q;

`ifdef PIPE_PERF_CNT_EN
    logic [CNT_W-1:0] stall_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_q <= '0;
        end else if (!pc_en_c && (stall_q != {CNT_W{1'b1}})) begin
            stall_q <= stall_q + CNT_W'(1);
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = '0;
`endif

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rst_n) begin
            assert (!(md_done && (state != ST_MD_WAIT)))
                else $error("md_done pulsed while not waiting on MUL/DIV");
            assert (!(md_start && branch_taken))
                else $error("md_start and branch_taken asserted together");
        end
    end
`endif

endmodule
